// File: rtl/event_input_fifo.sv
// -----------------------------------------------------------------------------
// event_input_fifo
//
// Buffers address-event (AER) coordinates from an upstream sensor interface
// and hands them one at a time to a convolution stage using an
// offer / ready / ack protocol. Events whose coordinates fall outside the
// image are discarded. Events that arrive while the FIFO is full are also
// discarded, unless an entry is popped in the same cycle.
//
// Ports
//   clk          : single clock; all state changes on the rising edge
//   reset        : asynchronous, active-low reset
//   in_valid     : upstream event present this cycle
//   in_x, in_y   : incoming event coordinate
//   in_ready     : high while the FIFO is not full
//   event_valid  : head event is offered to the convolution stage
//   event_coord  : head coordinate {x, y}; {0, 0} when nothing is held
//   event_ready  : convolution stage is idle and takes the offered event
//   event_ack    : one-cycle pulse; the convolution stage has consumed it
//   fifo_count   : current occupancy, 0..FIFO_DEPTH
//
// Optional build macro EVENT_DROP_STATS_EN adds two ports:
//   drop_full_cnt : saturating count of events dropped because FIFO was full
//   drop_oob_cnt  : saturating count of events dropped as out of bounds
// -----------------------------------------------------------------------------
module event_input_fifo #(
  parameter int COORD_BITS = 8,
  parameter int IMG_WIDTH  = 240,
  parameter int IMG_HEIGHT = 180,
  parameter int FIFO_DEPTH = 8    // power of two, >= 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [COORD_BITS-1:0]         in_x,
  input  logic [COORD_BITS-1:0]         in_y,
  output logic                          in_ready,
  output logic                          event_valid,
  output logic [2*COORD_BITS-1:0]       event_coord,
  input  logic                          event_ready,
  input  logic                          event_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef EVENT_DROP_STATS_EN
  ,
  output logic [15:0]                   drop_full_cnt,
  output logic [15:0]                   drop_oob_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_OFFER,
    ST_WAIT_ACK
  } state_e;

  logic [2*COORD_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  state_e                  state_q, state_d;
  logic                    event_valid_q, event_valid_d;

  logic in_bounds;
  logic full;
  logic push;
  logic pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; a missed branch would otherwise infer a latch.
    in_bounds = (int'(in_x) < IMG_WIDTH) && (int'(in_y) < IMG_HEIGHT);
    full      = (count_q == DEPTH_C);
    // The head only leaves on an ack while it is actually outstanding.
    pop       = (state_q == ST_WAIT_ACK) && event_ack;
    // A pop frees the slot under the write pointer, so a full FIFO can
    // still accept an event in the same cycle.
    push      = in_valid && in_bounds && (!full || pop);

    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

    state_d = state_q;
    unique case (state_q)
      // Look at the next count so a push into an empty FIFO is offered on
      // the very next cycle.
      ST_EMPTY:    if (count_d != '0) state_d = ST_OFFER;
      ST_OFFER:    if (event_ready)   state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: if (pop)           state_d = (count_d != '0) ? ST_OFFER : ST_EMPTY;
      default:                        state_d = ST_EMPTY;
    endcase

    event_valid_d = (state_d == ST_OFFER);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values; combinational blocks above use blocking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= ST_EMPTY;
      event_valid_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      event_valid_q <= event_valid_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count
  // define which entries are meaningful, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_x, in_y};
  end

  assign in_ready    = !full;
  assign event_valid = event_valid_q;
  assign fifo_count  = count_q;
  // The head is held stable through WAIT_ACK; nothing is popped until ack.
  assign event_coord = (state_q == ST_EMPTY) ? '0 : mem_q[rd_ptr_q];

`ifdef EVENT_DROP_STATS_EN
  logic        drop_full;
  logic        drop_oob;
  logic [15:0] drop_full_cnt_q, drop_full_cnt_d;
  logic [15:0] drop_oob_cnt_q,  drop_oob_cnt_d;

  always_comb begin
    drop_full       = in_valid && in_bounds && full && !pop;
    drop_oob        = in_valid && !in_bounds;
    drop_full_cnt_d = (drop_full && drop_full_cnt_q != 16'hFFFF) ?
                      drop_full_cnt_q + 16'd1 : drop_full_cnt_q;
    drop_oob_cnt_d  = (drop_oob && drop_oob_cnt_q != 16'hFFFF) ?
                      drop_oob_cnt_q + 16'd1 : drop_oob_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_full_cnt_q <= '0;
      drop_oob_cnt_q  <= '0;
    end else begin
      drop_full_cnt_q <= drop_full_cnt_d;
      drop_oob_cnt_q  <= drop_oob_cnt_d;
    end
  end

  assign drop_full_cnt = drop_full_cnt_q;
  assign drop_oob_cnt  = drop_oob_cnt_q;
`else
  // Without drop statistics, dropped events simply vanish.
`endif

endmodule

// File: doc/event_input_fifo.md
EVENT_INPUT_FIFO -- requirements
Module: event_input_fifo

Interface
REQ-001 Parameter COORD_BITS, default DEFAULT_COORD_BITS, width of each coordinate field.
REQ-002 Parameter IMG_WIDTH, default DEFAULT_IMG_WIDTH, valid x range 0..IMG_WIDTH-1.
REQ-003 Parameter IMG_HEIGHT, default DEFAULT_IMG_HEIGHT, valid y range 0..IMG_HEIGHT-1.
REQ-004 Parameter FIFO_DEPTH, default 8, entry count; power of two, >=2.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  upstream AER event present this cycle.
REQ-008 in_x, in_y  in  COORD_BITS each  incoming event coordinate.
REQ-009 in_ready  out  1  high when FIFO not full.
REQ-010 event_valid  out  1  head event offered to convolution stage.
REQ-011 event_coord  out  vec2_t  head coordinate {x, y}.
REQ-012 event_ready  in  1  convolution stage idle, able to sample.
REQ-013 event_ack  in  1  one-cycle pulse: convolution stage has consumed offered event.
REQ-014 fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-015 Push: in_valid high and (not full, or pop in same cycle) stores {in_x, in_y} at write pointer.
REQ-016 in_valid with FIFO full and no same-cycle pop: event dropped, FIFO unchanged.
REQ-017 in_x >= IMG_WIDTH or in_y >= IMG_HEIGHT: event dropped, never stored.
REQ-018 Pointers wrap modulo FIFO_DEPTH; fifo_count is exact across wrap.
REQ-019 Output FSM states: EMPTY, OFFER, WAIT_ACK.
REQ-020 EMPTY -> OFFER the cycle after fifo_count becomes nonzero; minimum push-to-event_valid latency 1 cycle.
REQ-021 OFFER: event_valid=1; event_coord=head; on event_valid && event_ready -> WAIT_ACK.
REQ-022 WAIT_ACK: event_valid=0; event_coord held stable at head; on event_ack pop head, go OFFER if remaining count >0, else EMPTY.
REQ-023 event_ack in EMPTY or OFFER ignored; no pop, no state change.
REQ-024 event_ready deasserted in OFFER: remain in OFFER, event_valid held, coord stable.
REQ-025 Simultaneous push and pop: both performed; count unchanged; legal when full.
REQ-026 event_coord outside WAIT_ACK/OFFER drives {0, 0}.
REQ-027 Events delivered strictly in arrival order; at most one event outstanding at a time.

Reset
REQ-028 reset low asynchronously clears pointers and fifo_count to 0, FSM to EMPTY.
REQ-029 During and after reset: event_valid=0, event_coord={0,0}, in_ready=1, fifo_count=0.
REQ-030 Reset mid-WAIT_ACK discards all entries; later event_ack ignored until a new event is offered.
REQ-031 Storage array contents need no reset.

Configuration
REQ-032 Macro EVENT_DROP_STATS_EN compiles in outputs drop_full_cnt and drop_oob_cnt, 16 bits each.
REQ-033 With EVENT_DROP_STATS_EN: each REQ-016 drop increments drop_full_cnt, each REQ-017 drop increments drop_oob_cnt; saturate at 16'hFFFF; cleared by reset.
REQ-034 Without EVENT_DROP_STATS_EN: ports and counters absent; drop behaviour identical.

Verification
REQ-035 Push (3,4) into empty FIFO, event_ready=1 -> event_valid=1 next cycle with event_coord={3,4}; ack after 1 cycle -> fifo_count=0, state EMPTY.
REQ-036 Push 8 events (depth 8) with event_ready=0, then 9th -> in_ready=0 after 8th, 9th dropped (drop_full_cnt=1 if enabled); drain yields 8 events in order.
REQ-037 Push (IMG_WIDTH, 0) and (0, IMG_HEIGHT) -> neither stored, fifo_count stays 0, drop_oob_cnt=2 if enabled.
REQ-038 FIFO full, event_ack and in_valid same cycle -> new event stored, fifo_count stays 8, next offered event is old second entry.
REQ-039 Assert reset low while in WAIT_ACK with 3 entries -> event_valid=0, fifo_count=0 immediately; subsequent event_ack causes no change.
REQ-040 Run 20 push/ack cycles through depth 8 -> pointer wrap, all 20 coordinates received in order, no loss.
